mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_mc_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / memory /
// write-back control with a bounded memory wait, misalignment and bus traps,
// and a halt state that is left by a run pulse.
module mc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            dec_reg_write,
    input  logic            dec_ecall,
    input  logic            jump_flag,
    input  logic [XLEN-1:0] alu_result,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic [XLEN-1:0] pc,
    input  logic            run,
    output logic            halted,
    output logic            trap_misalign,
    output logic            trap_bus,
    output logic [31:0]     instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT);

    logic [2:0]      state;
    // Low for the single cycle after reset release so no request is visible
    // while rst_n is still low; the first fetch appears after the first edge.
    logic            active;
    logic [15:0]     wcnt;
    logic            jmp_q;
    logic [XLEN-1:0] tgt_q;
    logic            ecall_halt;

    logic            retire;
    logic            ret_jmp;
    logic [XLEN-1:0] ret_tgt;
    logic            ret_mis;
    logic [XLEN-1:0] ret_pc;
    logic            mem_op;

    // Handshake outputs are pure decodes of the state so reset clears them at once.
    assign imem_req  = (state == S_FETCH) && active;
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) && dec_mem_write;
    assign rf_we     = (state == S_WB);
    assign halted    = (state == S_HALT);
    assign mem_op    = dec_mem_read | dec_mem_write;

    // Retire decision; in EXEC the jump inputs are used live since they are
    // being captured on the same edge.
    always_comb begin
        retire  = 1'b0;
        ret_jmp = jmp_q;
        ret_tgt = tgt_q;
        case (state)
            S_EXEC: begin
                retire  = !mem_op && !dec_reg_write;
                ret_jmp = jump_flag;
                ret_tgt = alu_result;
            end
            S_MEM:   retire = dmem_ack && !dec_mem_read;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
        ret_mis = ret_jmp && (ret_tgt[1:0] != 2'b00);
        ret_pc  = ret_jmp ? ret_tgt : pc + XLEN'(4);
    end

    // Main sequencer state, pc, counters and trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            active        <= 1'b0;
            wcnt          <= '0;
            pc            <= RESET_PC;
            instr         <= '0;
            instret       <= '0;
            jmp_q         <= 1'b0;
            tgt_q         <= '0;
            trap_misalign <= 1'b0;
            trap_bus      <= 1'b0;
            ecall_halt    <= 1'b0;
        end else begin
            active <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (active) begin
                        if (imem_ack) begin
                            instr <= imem_rdata;
                            state <= S_DECODE;
                        end else if (wcnt == WAIT_MAX) begin
                            trap_bus <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            wcnt <= wcnt + 16'd1;
                        end
                    end
                end
                S_DECODE: begin
                    if (dec_ecall) begin
                        ecall_halt <= 1'b1;
                        state      <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    jmp_q <= jump_flag;
                    tgt_q <= alu_result;
                    if (mem_op) begin
                        wcnt  <= '0;
                        state <= S_MEM;
                    end else if (dec_reg_write) begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (dec_mem_read) state <= S_WB;
                    end else if (wcnt == WAIT_MAX) begin
                        trap_bus <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                S_HALT: begin
                    if (run) begin
                        trap_misalign <= 1'b0;
                        trap_bus      <= 1'b0;
                        ecall_halt    <= 1'b0;
                        // ecall completes on resume; traps re-execute the same pc
                        if (ecall_halt) begin
                            pc      <= pc + XLEN'(4);
                            instret <= instret + 32'd1;
                        end
                        wcnt  <= '0;
                        state <= S_FETCH;
                    end
                end
                default: state <= state;
            endcase

            if (retire) begin
                if (ret_mis) begin
                    trap_misalign <= 1'b1;
                    state         <= S_HALT;
                end else begin
                    pc      <= ret_pc;
                    instret <= instret + 32'd1;
                    wcnt    <= '0;
                    state   <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: table of directed instructions, hand-written reset
// sequences and a randomized run against an instruction-level model.
module tb_mc_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        dec_mem_read = 1'b0;
    logic        dec_mem_write = 1'b0;
    logic        dec_reg_write = 1'b0;
    logic        dec_ecall = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] alu_result = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic [31:0] pc;
    logic        run = 1'b0;
    logic        halted;
    logic        trap_misalign;
    logic        trap_bus;
    logic [31:0] instret;

    mc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_ecall(dec_ecall),
        .jump_flag(jump_flag), .alu_result(alu_result),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc(pc), .run(run), .halted(halted),
        .trap_misalign(trap_misalign), .trap_bus(trap_bus), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // architectural model: pc, retired count, halt and its cause
    logic [31:0] pc_m;
    logic [31:0] ir_m;
    logic        halt_m, mis_m, bus_m, ecall_m;

    typedef struct {
        logic        rd, wr, rw, ec, jf;
        logic [31:0] tgt;
        int          ilat, dlat;
        logic [31:0] e_pc, e_ir;
        logic        e_halt, e_mis, e_bus;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Drive one instruction from its FETCH cycle to completion, checking the
    // handshake cycle by cycle and updating the model. Latency above TO
    // means the ack never comes.
    task automatic do_instr(input logic rd, input logic wr, input logic rw, input logic ec,
                            input logic jf, input logic [31:0] tgt, input int ilat, input int dlat);
        logic [31:0] word;
        logic        mem;
        bit          done;
        word = $urandom;
        dec_mem_read = rd; dec_mem_write = wr; dec_reg_write = rw; dec_ecall = ec;
        jump_flag = jf; alu_result = tgt;
        done = 0;
        for (int k = 0; k <= TO; k++) begin
            chk1("fetch_req", imem_req, 1'b1);
            chk("fetch_addr", imem_addr, pc_m);
            chk1("fetch_rfwe", rf_we, 1'b0);
            imem_ack = (k == ilat); imem_rdata = word; dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            imem_ack = 1'b0; dmem_ack = 1'b0;
            if (k == ilat) begin done = 1; break; end
        end
        if (!done) begin bus_m = 1'b1; halt_m = 1'b1; return; end
        // DECODE
        chk("dec_instr", instr, word);
        chk("dec_idle", 32'({imem_req, dmem_req, rf_we, halted}), 32'h0);
        run = 1'($urandom_range(0, 1));
        @(negedge clk);
        run = 1'b0;
        if (ec) begin ecall_m = 1'b1; halt_m = 1'b1; return; end
        // EXEC
        chk("exec_idle", 32'({imem_req, dmem_req, rf_we, halted}), 32'h0);
        imem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_ack = 1'b0;
        // the jump decision must have been captured in EXEC
        jump_flag = 1'($urandom_range(0, 1)); alu_result = $urandom;
        mem = rd | wr;
        if (mem) begin
            done = 0;
            for (int k = 0; k <= TO; k++) begin
                chk1("mem_req", dmem_req, 1'b1);
                chk1("mem_we", dmem_we, wr);
                chk1("mem_noimem", imem_req, 1'b0);
                dmem_ack = (k == dlat);
                @(negedge clk);
                dmem_ack = 1'b0;
                if (k == dlat) begin done = 1; break; end
            end
            if (!done) begin bus_m = 1'b1; halt_m = 1'b1; return; end
        end
        if (rd || (!mem && rw)) begin
            chk1("wb_rfwe", rf_we, 1'b1);
            chk("wb_noreq", 32'({imem_req, dmem_req}), 32'h0);
            @(negedge clk);
        end
        chk1("post_rfwe", rf_we, 1'b0);
        if (jf && (tgt[1:0] != 2'b00)) begin
            mis_m = 1'b1; halt_m = 1'b1;
        end else begin
            pc_m = jf ? tgt : pc_m + 32'd4;
            ir_m = ir_m + 32'd1;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pc"}, pc, pc_m);
        chk({tag, "_instret"}, instret, ir_m);
        chk1({tag, "_halted"}, halted, halt_m);
        chk1({tag, "_mis"}, trap_misalign, mis_m);
        chk1({tag, "_bus"}, trap_bus, bus_m);
        chk1({tag, "_ireq"}, imem_req, !halt_m);
        chk("_idle", 32'({dmem_req, rf_we}), 32'h0);
    endtask

    // Stay halted one cycle, then pulse run.
    task automatic do_run();
        @(negedge clk);
        chk1("halt_hold", halted, 1'b1);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        if (ecall_m) begin pc_m = pc_m + 32'd4; ir_m = ir_m + 32'd1; end
        ecall_m = 1'b0; mis_m = 1'b0; bus_m = 1'b0; halt_m = 1'b0;
    endtask

    initial begin
        logic        rd, wr, rw, ec, jf;
        logic [31:0] tgt;
        int          kind, ilat, dlat;

        //          rd  wr  rw  ec  jf  tgt            il dl  e_pc           e_ir   h  m  b
        tbl[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        0, 0, 32'h4,        32'd1, 1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        0, 3, 32'h8,        32'd2, 1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        0, 0, 32'hC,        32'd3, 1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        2, 0, 32'h10,       32'd4, 1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,32'h100,      0, 0, 32'h100,      32'd5, 1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,32'h102,      0, 0, 32'h100,      32'd5, 1'b1,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h20,       1, 0, 32'h20,       32'd6, 1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        0, 0, 32'h20,       32'd6, 1'b1,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        9, 0, 32'h24,       32'd7, 1'b1,1'b0,1'b1};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        4, 0, 32'h28,       32'd8, 1'b0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        0, 9, 32'h28,       32'd8, 1'b1,1'b0,1'b1};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'd9, 1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        0, 0, 32'h0,        32'd10,1'b0,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b1,1'b1,1'b0,1'b1,32'h40,       0, 2, 32'h40,       32'd11,1'b0,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b1,1'b0,1'b1,32'h43,       0, 1, 32'h40,       32'd11,1'b1,1'b1,1'b0};

        pc_m = 32'h0; ir_m = 32'h0;
        halt_m = 1'b0; mis_m = 1'b0; bus_m = 1'b0; ecall_m = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_reqs", 32'({imem_req, dmem_req, dmem_we, rf_we, halted, trap_misalign, trap_bus}), 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_instr", instr, 32'h0);
        rst_n = 1'b1;
        #1 chk1("rel_noreq", imem_req, 1'b0);
        @(negedge clk);

        // directed table
        for (int i = 0; i < 15; i++) begin
            do_instr(tbl[i].rd, tbl[i].wr, tbl[i].rw, tbl[i].ec, tbl[i].jf, tbl[i].tgt,
                     tbl[i].ilat, tbl[i].dlat);
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_instret", i), instret, tbl[i].e_ir);
            chk1($sformatf("tbl%0d_halted", i), halted, tbl[i].e_halt);
            chk1($sformatf("tbl%0d_mis", i), trap_misalign, tbl[i].e_mis);
            chk1($sformatf("tbl%0d_bus", i), trap_bus, tbl[i].e_bus);
            check_state("tblm");
            if (halt_m) begin
                do_run();
                check_state("tbl_run");
            end
        end

        // reset asserted mid-MEM with dmem_req high
        dec_mem_read = 1'b1; dec_mem_write = 1'b0; dec_reg_write = 1'b1; dec_ecall = 1'b0;
        jump_flag = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk1("midmem_req", dmem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_dmem_req", dmem_req, 1'b0);
        chk("async_pc", pc, 32'h0);
        chk("async_instret", instret, 32'h0);
        chk("async_misc", 32'({imem_req, rf_we, halted, trap_misalign, trap_bus}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pc_m = 32'h0; ir_m = 32'h0;
        halt_m = 1'b0; mis_m = 1'b0; bus_m = 1'b0; ecall_m = 1'b0;
        chk1("rel2_noreq", imem_req, 1'b0);
        @(negedge clk);
        chk1("first_fetch", imem_req, 1'b1);

        // randomized instruction stream
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 8);
            rd = (kind == 3 || kind == 4);
            wr = (kind == 5 || kind == 6);
            rw = (kind <= 4) || (kind == 8 && $urandom_range(0, 1) == 1);
            ec = (kind == 8);
            jf = ($urandom_range(0, 3) == 0);
            tgt = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            ilat = ($urandom_range(0, 11) == 0) ? 7 : $urandom_range(0, TO);
            dlat = ($urandom_range(0, 11) == 0) ? 7 : $urandom_range(0, TO);
            do_instr(rd, wr, rw, ec, jf, tgt, ilat, dlat);
            check_state("rnd");
            if (halt_m) begin
                do_run();
                check_state("rnd_run");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
